// File: rtl/systolic_array_sequencer.sv
// rtl/systolic_array_sequencer.sv - weight-load / ifmap-stream / ofmap-deskew sequencer for a skewed systolic array
// Optional feature macro: SA_SEQ_WEIGHT_REUSE_EN (start with keep_weights=1 skips the weight load)
module systolic_array_sequencer #(
  parameter int IFMAP_WIDTH   = 16,
  parameter int WEIGHT_WIDTH  = 16,
  parameter int OFMAP_WIDTH   = 32,
  parameter int ARRAY_HEIGHT  = 4,
  parameter int ARRAY_WIDTH   = 4,
  parameter int ARRAY_LATENCY = ARRAY_HEIGHT + ARRAY_WIDTH,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [CNT_WIDTH-1:0]                  num_vectors,
  input  logic                                  keep_weights,
  output logic                                  busy,
  output logic                                  done,
  input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]   weight_data,
  input  logic                                  weight_valid,
  output logic                                  weight_ready,
  input  logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0]   ifmap_data,
  input  logic                                  ifmap_valid,
  output logic                                  ifmap_ready,
  output logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0]    ofmap_data,
  output logic                                  ofmap_valid,
  input  logic                                  ofmap_ready,
  output logic                                  arr_en,
  output logic                                  arr_weight_en,
  output logic [ARRAY_HEIGHT-1:0]               arr_weight_wen,
  output logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0]   arr_ifmap,
  output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]   arr_weight,
  output logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0]    arr_ofmap_in,
  input  logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0]    arr_ofmap
);

  localparam int ROW_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
  localparam logic [ROW_W-1:0]        LAST_ROW = ROW_W'(ARRAY_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ARRAY_HEIGHT-1:0] WEN_ONE  = ARRAY_HEIGHT'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN} state_t;

  state_t                   state;
  logic [ROW_W-1:0]         row;
  logic [CNT_WIDTH-1:0]     cnt;
  logic [CNT_WIDTH-1:0]     nv;
  logic [ARRAY_LATENCY-1:0] vld_sr;
  logic                     reuse_req;
  logic                     w_acc;
  logic                     ifmap_acc;

`ifdef SA_SEQ_WEIGHT_REUSE_EN
  assign reuse_req = keep_weights;
`else
  logic keep_weights_unused;
  assign keep_weights_unused = keep_weights;
  assign reuse_req = 1'b0;
`endif

  // Bit i of vld_sr marks a real vector i en-cycles deep in the array; the top bit lines up with arr_ofmap.
  assign ofmap_valid  = vld_sr[ARRAY_LATENCY-1];
  assign ofmap_data   = ofmap_valid ? arr_ofmap : '0;

  // The whole array freezes while a result waits, which keeps ofmap_data stable for free.
  assign arr_en       = busy && (state != S_LOAD_W) && !(ofmap_valid && !ofmap_ready);
  assign ifmap_ready  = (state == S_STREAM) && arr_en;
  assign ifmap_acc    = ifmap_ready && ifmap_valid;
  assign w_acc        = weight_ready && weight_valid;

  assign arr_weight_en  = weight_ready;
  assign arr_weight_wen = w_acc ? (WEN_ONE << row) : '0;
  assign arr_weight     = w_acc ? weight_data : '0;
  assign arr_ifmap      = ifmap_acc ? ifmap_data : '0;
  assign arr_ofmap_in   = '0;
  assign done           = (state == S_DRAIN) && (vld_sr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      row          <= '0;
      cnt          <= '0;
      nv           <= '0;
      vld_sr       <= '0;
      busy         <= 1'b0;
      weight_ready <= 1'b0;
    end else begin
      if (arr_en) vld_sr <= {vld_sr[ARRAY_LATENCY-2:0], ifmap_acc};
      case (state)
        S_IDLE: begin
          if (start) begin
            nv   <= num_vectors;
            cnt  <= '0;
            row  <= '0;
            busy <= 1'b1;
            if (reuse_req) begin
              state <= (num_vectors == '0) ? S_DRAIN : S_STREAM;
            end else begin
              state        <= S_LOAD_W;
              weight_ready <= 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (w_acc) begin
            row <= row + ROW_W'(1);
            if (row == LAST_ROW) begin
              weight_ready <= 1'b0;
              state        <= (nv == '0) ? S_DRAIN : S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (ifmap_acc) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == nv - CNT_ONE) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (vld_sr == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
